// File: rtl/nibble_deserializer.sv
// Serial-to-parallel receiver: steers accepted bits into a nibble accumulator
// and hands finished nibbles to a one-entry valid/ready output register.
module nibble_deserializer #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_clear,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_count,
  output logic       busy
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; ready never depends combinationally on the
  // other side's ready, and out_data is held while out_valid is high and unconsumed.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam bit LSB = (LSB_FIRST != 0);

  state_t     state, state_nxt;
  logic [3:0] acc, acc_nxt, acc_bit;
  logic [1:0] idx, idx_nxt, lane;
  logic [3:0] out_data_nxt;
  logic       out_valid_nxt;
  logic [7:0] out_count_nxt;
  logic       accept, drain;

  assign in_ready = (state != FULL);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign lane     = LSB ? idx : (2'd3 - idx);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    idx_nxt       = idx;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_count_nxt = out_count;
    acc_bit       = acc;
    acc_bit[lane] = in_bit;

    if (drain) begin
      out_valid_nxt = 1'b0;
      out_count_nxt = out_count + 8'd1;
    end

    // Clear outranks any accept or refill but never touches the output side.
    if (in_clear) begin
      state_nxt = IDLE;
      acc_nxt   = 4'd0;
      idx_nxt   = 2'd0;
    end else if (state == FULL) begin
      if (drain) begin
        out_data_nxt  = acc;
        out_valid_nxt = 1'b1;
        acc_nxt       = 4'd0;
        idx_nxt       = 2'd0;
        state_nxt     = IDLE;
      end
    end else if (accept) begin
      idx_nxt = idx + 2'd1;
      if (idx == 2'd3) begin
        if (!out_valid || drain) begin
          out_data_nxt  = acc_bit;
          out_valid_nxt = 1'b1;
          acc_nxt       = 4'd0;
          state_nxt     = IDLE;
        end else begin
          acc_nxt   = acc_bit;
          state_nxt = FULL;
        end
      end else begin
        acc_nxt   = acc_bit;
        state_nxt = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 4'd0;
      idx       <= 2'd0;
      out_data  <= 4'd0;
      out_valid <= 1'b0;
      out_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      idx       <= idx_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_count <= out_count_nxt;
    end
  end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed bench for nibble_deserializer: one LSB-first and one MSB-first
// instance share stimulus; each scenario task checks its own results.
module tb_nibble_deserializer;

  logic       clk, rst_n;
  logic       in_bit, in_valid, in_clear, out_ready;
  logic       in_ready_l, out_valid_l, busy_l;
  logic [3:0] out_data_l;
  logic [7:0] out_count_l;
  logic       in_ready_m, out_valid_m, busy_m;
  logic [3:0] out_data_m;
  logic [7:0] out_count_m;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  nibble_deserializer #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_l), .in_clear(in_clear), .out_data(out_data_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_count(out_count_l),
    .busy(busy_l)
  );

  nibble_deserializer #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_m), .in_clear(in_clear), .out_data(out_data_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_count(out_count_m),
    .busy(busy_m)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_clear = 1'b0; out_ready = 1'b0;
  end

  // Driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_clear = 1'b0; out_ready = 1'b0; in_bit = 1'b0;
    step;
    step;
    rst_n = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    step;
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({out_data_l, out_valid_l, out_count_l, busy_l, in_ready_l} !== {4'h0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got data=%h v=%b cnt=%0d busy=%b rdy=%b, expected 0 0 0 0 1",
               out_data_l, out_valid_l, out_count_l, busy_l, in_ready_l);
    end
  endtask

  task automatic test_lsb_first;
    do_reset;
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    total++;
    if (out_valid_l !== 1'b0) begin
      bad++; $display("FAIL lsb_early_valid: got %b expected 0", out_valid_l);
    end
    send_bit(1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid_l !== 1'b1 || out_data_l !== 4'hD) begin
      bad++; $display("FAIL lsb_data: got v=%b data=%h expected v=1 data=d", out_valid_l, out_data_l);
    end
    step;
    total++;
    if (out_valid_l !== 1'b0 || out_count_l !== 8'd1) begin
      bad++; $display("FAIL lsb_drain: got v=%b cnt=%0d expected v=0 cnt=1", out_valid_l, out_count_l);
    end
  endtask

  task automatic test_msb_first;
    do_reset;
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid_m !== 1'b1 || out_data_m !== 4'hB) begin
      bad++; $display("FAIL msb_data: got v=%b data=%h expected v=1 data=b", out_valid_m, out_data_m);
    end
  endtask

  task automatic test_stall;
    do_reset;
    out_ready = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    total++;
    if (out_valid_l !== 1'b1 || out_data_l !== 4'hA) begin
      bad++; $display("FAIL stall_first: got v=%b data=%h expected v=1 data=a", out_valid_l, out_data_l);
    end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    total++;
    if (in_ready_l !== 1'b1) begin
      bad++; $display("FAIL stall_ready_before: got %b expected 1", in_ready_l);
    end
    send_bit(1'b0);
    total++;
    if (in_ready_l !== 1'b0 || out_data_l !== 4'hA || busy_l !== 1'b1) begin
      bad++; $display("FAIL stall_full: got rdy=%b data=%h busy=%b expected 0 a 1", in_ready_l, out_data_l, busy_l);
    end
    send_bit(1'b1);
    in_valid = 1'b0;
    total++;
    if (in_ready_l !== 1'b0 || out_data_l !== 4'hA) begin
      bad++; $display("FAIL stall_ignore: got rdy=%b data=%h expected 0 a", in_ready_l, out_data_l);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    total++;
    if ({out_data_l, out_valid_l, in_ready_l, out_count_l, busy_l} !== {4'h5, 1'b1, 1'b1, 8'd1, 1'b0}) begin
      bad++; $display("FAIL stall_refill: got data=%h v=%b rdy=%b cnt=%0d busy=%b expected 5 1 1 1 0",
                      out_data_l, out_valid_l, in_ready_l, out_count_l, busy_l);
    end
    step;
    total++;
    if (out_data_l !== 4'h5 || out_valid_l !== 1'b1) begin
      bad++; $display("FAIL stall_hold: got data=%h v=%b expected 5 1", out_data_l, out_valid_l);
    end
  endtask

  task automatic test_clear;
    do_reset;
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    total++;
    if (busy_l !== 1'b1) begin
      bad++; $display("FAIL clear_busy_before: got %b expected 1", busy_l);
    end
    in_clear = 1'b1;
    send_bit(1'b1);
    in_clear = 1'b0;
    total++;
    if (busy_l !== 1'b0 || out_valid_l !== 1'b0) begin
      bad++; $display("FAIL clear_abort: got busy=%b v=%b expected 0 0", busy_l, out_valid_l);
    end
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid_l !== 1'b1 || out_data_l !== 4'h8) begin
      bad++; $display("FAIL clear_data: got v=%b data=%h expected 1 8", out_valid_l, out_data_l);
    end
    step;
    total++;
    if (out_valid_l !== 1'b0 || busy_l !== 1'b0 || out_count_l !== 8'd1) begin
      bad++; $display("FAIL clear_after: got v=%b busy=%b cnt=%0d expected 0 0 1", out_valid_l, busy_l, out_count_l);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    in_valid = 1'b0;
    total++;
    if (in_ready_l !== 1'b0 || out_valid_l !== 1'b1) begin
      bad++; $display("FAIL areset_setup: got rdy=%b v=%b expected 0 1", in_ready_l, out_valid_l);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_data_l, out_valid_l, out_count_l, busy_l, in_ready_l} !== {4'h0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL areset_now: got data=%h v=%b cnt=%0d busy=%b rdy=%b expected 0 0 0 0 1",
                      out_data_l, out_valid_l, out_count_l, busy_l, in_ready_l);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid_l !== 1'b1 || out_data_l !== 4'hF || out_count_l !== 8'd0) begin
      bad++; $display("FAIL areset_after: got v=%b data=%h cnt=%0d expected 1 f 0", out_valid_l, out_data_l, out_count_l);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] val, exp;
    do_reset;
    out_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      val = 4'((n * 5 + 3) % 16);
      exp_q.push_back(val);
      for (int b = 0; b < 4; b++) send_bit(val[b]);
      exp = exp_q.pop_front();
      total++;
      if (out_valid_l !== 1'b1 || out_data_l !== exp || out_count_l !== 8'(n) || in_ready_l !== 1'b1) begin
        bad++; $display("FAIL b2b_nibble%0d: got v=%b data=%h cnt=%0d rdy=%b expected 1 %h %0d 1",
                        n, out_valid_l, out_data_l, out_count_l, in_ready_l, exp, n[7:0]);
      end
    end
    in_valid = 1'b0;
    step;
    total++;
    if (out_count_l !== 8'd0 || out_valid_l !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_wrap: got cnt=%0d v=%b left=%0d expected 0 0 0", out_count_l, out_valid_l, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_lsb_first;
    test_msb_first;
    test_stall;
    test_clear;
    test_async_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
Serial-to-parallel receiver that assembles a 1-bit stream into 4-bit operands for the 4-bit ALU datapath. It is the receive-side counterpart of the 4:1 bit-select path. A 2-bit index steers each accepted bit into one lane of a nibble accumulator, demux-style. Completed nibbles pass to a one-entry output register with valid/ready handshake, so the next nibble can accumulate while the consumer stalls.

Parameters:
LSB_FIRST, 1, 1: first accepted bit lands in bit 0; 0: first accepted bit lands in bit 3.

Ports:
clk  input  1  sole clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_bit  input  1  serial data bit.
in_valid  input  1  in_bit is valid this cycle.
in_ready  output  1  block accepts in_bit this cycle.
in_clear  input  1  synchronous abort of the partial nibble.
out_data  output  4  assembled nibble.
out_valid  output  1  out_data holds an unconsumed nibble.
out_ready  input  1  consumer accepts out_data this cycle.
out_count  output  8  count of nibbles delivered, modulo 256.
busy  output  1  accumulator holds at least one bit.

Behaviour:
- Reset (asynchronous, rst_n=0): takes effect immediately, regardless of clk.
  - acc=0, idx=0, state=IDLE.
  - out_data=0, out_valid=0, out_count=0, busy=0, in_ready=1.
- Reset during accumulation or while out_valid=1 discards all data, with no partial output.
- Accumulator FSM:
  - IDLE: idx=0, no bits held.
  - ACCUM: idx=1..3.
  - FULL: 4 bits held, waiting for the output register.
- Output signals:
  - in_ready = (state!=FULL). It is a function of registers only, with no combinational path from out_ready.
  - busy = (state!=IDLE).
- Bit accept (in_valid & in_ready):
  - Lane written is idx when LSB_FIRST=1, else 3-idx.
  - idx increments by 1 and wraps from 3 to 0.
  - IDLE→ACCUM on the first bit.
- 4th bit accepted (idx=3):
  - If out_valid=0, or out_valid & out_ready this cycle: the complete nibble, including this bit, loads out_data at the edge. out_valid=1 next cycle; state→IDLE.
  - Otherwise: state→FULL, and in_ready=0 from the next cycle.
- In FULL:
  - When out_valid & out_ready, acc loads out_data at that edge; out_valid stays 1; state→IDLE. in_ready returns to 1 the following cycle.
  - in_valid is ignored while in FULL.
- Latency: out_valid rises exactly 1 cycle after the edge that accepted the 4th bit when the output register is free. Sustained throughput is 1 nibble per 4 clocks.
- Output handshake:
  - out_valid & out_ready with no refill pending: out_valid=0 next cycle.
  - out_data stays stable while out_valid=1 and out_ready=0.
- in_clear=1:
  - acc=0, idx=0, state=IDLE next cycle.
  - A bit accepted in the same cycle is dropped; clear wins, including on a 4th bit.
  - A FULL accumulator is discarded.
  - The output register, out_valid and out_count are unaffected.
- out_count: +1 on each out_valid & out_ready; wraps 255→0.
- Simultaneous events in one cycle: output drain, FULL refill and in_clear. Drain and count apply; clear discards the refill.

Test Plan:
1. LSB_FIRST=1, out_ready=1, bits 1,0,1,1 on 4 consecutive cycles → out_data=4'hD, out_valid high for 1 cycle starting 1 cycle after the 4th bit, out_count=1.
2. LSB_FIRST=0, same bits → out_data=4'hB.
3. out_ready=0, stream nibbles 4'hA then 4'h5 (LSB first) →
   - out_data holds 4'hA.
   - in_ready falls the cycle after the 8th bit.
   - Raise out_ready for 1 cycle → out_data=4'h5 next cycle, out_valid stays 1, in_ready=1 the following cycle, out_count=1.
4. 2 bits accepted, then in_clear pulse, then bits 0,0,0,1 → single output 4'h8, busy=0 after delivery.
5. rst_n low mid-nibble with out_valid=1 and state FULL → all outputs at reset values without a clock edge; after release, the next 4 bits 1,1,1,1 give 4'hF.
6. 256 back-to-back nibbles with out_ready=1 → out_count wraps to 0; no bit lost, with every out_data matching the stimulus.
